// File: rtl/fetch_decode.sv
`timescale 1ns/1ps
// fetch_decode: fetches a two- or three-word instruction over a req/ack memory
// port, decodes it into registered datapath control fields and issues a single
// write pulse per instruction.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   program_counter     base address of the next instruction (sampled in FETCH0)
//   imem_req/imem_addr  instruction memory request and address (held until ack)
//   imem_ack/imem_data  memory acknowledge and read data (captured on ack edge)
//   halt                stalls the decoder in ISSUE with no write
//   op..copy_select     decoded fields, registered on capture edges
//   write, issue        write enable pulse and its strobe, live one ISSUE cycle
//   illegal             sticky flag for nonzero reserved bits in word1
module fetch_decode #(
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] program_counter,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        halt,
  output logic [2:0]  op,
  output logic        form,
  output logic [1:0]  vec,
  output logic [3:0]  alu_config,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [3:0]  C,
  output logic [3:0]  D,
  output logic [3:0]  Y1,
  output logic [3:0]  Y2,
  output logic [1:0]  write,
  output logic        const_c,
  output logic        pc_inc,
  output logic [31:0] constant,
  output logic [3:0]  copy_select,
  output logic        issue,
  output logic        illegal
);

  localparam logic [31:0] Step = 32'(ADDR_STEP);

  typedef enum logic [2:0] {
    StFetch0,
    StFetch1,
    StFetch2,
    StIssue,
    StSettle
  } state_e;

  state_e     state;
  logic [1:0] write_field;
  logic       reserved_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StFetch0;
      imem_req     <= 1'b0;
      imem_addr    <= '0;
      op           <= '0;
      form         <= 1'b0;
      vec          <= '0;
      alu_config   <= '0;
      A            <= '0;
      B            <= '0;
      C            <= '0;
      D            <= '0;
      Y1           <= '0;
      Y2           <= '0;
      const_c      <= 1'b0;
      pc_inc       <= 1'b0;
      constant     <= '0;
      copy_select  <= '0;
      illegal      <= 1'b0;
      write_field  <= '0;
      reserved_bad <= 1'b0;
    end else begin
      unique case (state)
        StFetch0: begin
          // First FETCH0 cycle only launches the request; acks are ignored until
          // imem_req is actually high.
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= program_counter;
          end else if (imem_ack) begin
            op          <= imem_data[31:29];
            form        <= imem_data[28];
            vec         <= imem_data[27:26];
            write_field <= imem_data[25:24];
            A           <= imem_data[23:20];
            B           <= imem_data[19:16];
            C           <= imem_data[15:12];
            D           <= imem_data[11:8];
            Y1          <= imem_data[7:4];
            Y2          <= imem_data[3:0];
            imem_addr   <= imem_addr + Step;
            state       <= StFetch1;
          end
        end
        StFetch1: begin
          if (imem_ack) begin
            const_c      <= imem_data[31];
            pc_inc       <= imem_data[30];
            alu_config   <= imem_data[29:26];
            copy_select  <= imem_data[25:22];
            reserved_bad <= |imem_data[21:0];
            if (|imem_data[21:0]) illegal <= 1'b1;
            if (imem_data[31]) begin
              imem_addr <= imem_addr + Step;
              state     <= StFetch2;
            end else begin
              imem_req <= 1'b0;
              state    <= StIssue;
            end
          end
        end
        StFetch2: begin
          if (imem_ack) begin
            constant <= imem_data;
            imem_req <= 1'b0;
            state    <= StIssue;
          end
        end
        StIssue: begin
          if (!halt) state <= StSettle;
        end
        StSettle: begin
          state <= StFetch0;
        end
        default: begin
          imem_req <= 1'b0;
          state    <= StFetch0;
        end
      endcase
    end
  end

  // The write pulse must drop in the very cycle halt is high, so it is gated
  // from registered state rather than registered itself.
  always_comb begin
    issue = (state == StIssue) && !halt;
    write = (issue && !reserved_bad) ? write_field : 2'b00;
  end

endmodule

// File: tb/tb_fetch_decode.sv
`timescale 1ns/1ps
// tb_fetch_decode: directed plus randomized instruction sequences driven through a
// cycle-exact memory responder; expected fields come from the word layouts.
module tb_fetch_decode;

  localparam int unsigned Step = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] program_counter;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        halt;
  logic [2:0]  op;
  logic        form;
  logic [1:0]  vec;
  logic [3:0]  alu_config;
  logic [3:0]  A, B, C, D, Y1, Y2;
  logic [1:0]  write;
  logic        const_c;
  logic        pc_inc;
  logic [31:0] constant;
  logic [3:0]  copy_select;
  logic        issue;
  logic        illegal;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  logic        ill_model = 1'b0;
  logic [31:0] const_model = '0;

  always #5 clk = ~clk;

  fetch_decode #(.ADDR_STEP(Step)) dut (
    .clk(clk), .rst_n(rst_n), .program_counter(program_counter),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .halt(halt), .op(op), .form(form), .vec(vec),
    .alu_config(alu_config), .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2),
    .write(write), .const_c(const_c), .pc_inc(pc_inc), .constant(constant),
    .copy_select(copy_select), .issue(issue), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input logic [31:0] w0, input logic [31:0] w1);
    chk({tag, "_op"},   32'(op),          (w0 >> 29) & 7);
    chk({tag, "_form"}, 32'(form),        (w0 >> 28) & 1);
    chk({tag, "_vec"},  32'(vec),         (w0 >> 26) & 3);
    chk({tag, "_A"},    32'(A),           (w0 >> 20) & 15);
    chk({tag, "_B"},    32'(B),           (w0 >> 16) & 15);
    chk({tag, "_C"},    32'(C),           (w0 >> 12) & 15);
    chk({tag, "_D"},    32'(D),           (w0 >> 8) & 15);
    chk({tag, "_Y1"},   32'(Y1),          (w0 >> 4) & 15);
    chk({tag, "_Y2"},   32'(Y2),          w0 & 15);
    chk({tag, "_cc"},   32'(const_c),     (w1 >> 31) & 1);
    chk({tag, "_pci"},  32'(pc_inc),      (w1 >> 30) & 1);
    chk({tag, "_alu"},  32'(alu_config),  (w1 >> 26) & 15);
    chk({tag, "_cpy"},  32'(copy_select), (w1 >> 22) & 15);
    chk({tag, "_const"}, constant,        const_model);
    chk({tag, "_ill"},  32'(illegal),     32'(ill_model));
  endtask

  // Serves one memory word after 'waits' stall cycles; the PC input is scrambled
  // while stalled since it must not influence an instruction in flight.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", 32'(imem_req), 1);
      chk("wait_addr", imem_addr, addr);
      imem_ack = 1'b0;
      imem_data = $urandom;
      program_counter = $urandom;
      tick();
    end
    chk("req", 32'(imem_req), 1);
    chk("addr", imem_addr, addr);
    imem_ack = 1'b1;
    imem_data = data;
    tick();
    imem_ack = 1'b0;
  endtask

  // Starts in the idle FETCH0 cycle, returns in the next idle FETCH0 cycle.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input int wt0, input int wt1, input int wt2,
                           input int halt_cycles);
    logic        bad;
    logic [31:0] a1, a2;
    a1 = pc + Step;
    a2 = pc + 2 * Step;
    chk("idle_req", 32'(imem_req), 0);
    chk("idle_issue", 32'(issue), 0);
    program_counter = pc;
    imem_ack = 1'($urandom % 2);
    tick();
    imem_ack = 1'b0;
    fetch_word(pc, w0, wt0);
    fetch_word(a1, w1, wt1);
    if (w1[31]) begin
      fetch_word(a2, w2, wt2);
      const_model = w2;
    end
    bad = (w1 & 32'h003F_FFFF) != 0;
    if (bad) ill_model = 1'b1;
    chk("issue_req", 32'(imem_req), 0);
    check_fields("issue", w0, w1);
    for (int i = 0; i < halt_cycles; i++) begin
      halt = 1'b1;
      imem_ack = 1'($urandom % 2);
      #1;
      chk("halt_write", 32'(write), 0);
      chk("halt_issue", 32'(issue), 0);
      tick();
    end
    halt = 1'b0;
    imem_ack = 1'($urandom % 2);
    #1;
    chk("write", 32'(write), bad ? 32'd0 : ((w0 >> 24) & 3));
    chk("issue", 32'(issue), 1);
    tick();
    imem_ack = 1'($urandom % 2);
    chk("settle_write", 32'(write), 0);
    chk("settle_issue", 32'(issue), 0);
    chk("settle_req", 32'(imem_req), 0);
    check_fields("settle", w0, w1);
    tick();
    imem_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_issue"}, 32'(issue), 0);
    chk({tag, "_write"}, 32'(write), 0);
    chk({tag, "_ill"}, 32'(illegal), 0);
    chk({tag, "_fields"}, {op, form, vec, A, B, C, D, Y1, Y2}, 0);
    chk({tag, "_fields1"}, {const_c, pc_inc, alu_config, copy_select}, 0);
    chk({tag, "_const"}, constant, 0);
  endtask

  initial begin
    logic [31:0] w0, w1, pc;
    rst_n = 1'b0;
    program_counter = 32'h10;
    imem_ack = 1'b0;
    imem_data = '0;
    halt = 1'b0;
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic two-word instruction, zero-wait memory.
    run_instr(32'h10, 32'h2F4A_1234, 32'h0, 32'h0, 0, 0, 0, 0);
    chk("d1_op", 32'(op), 1);
    chk("d1_vec", 32'(vec), 3);
    chk("d1_ABCD", {A, B, C, D}, 32'h4A12);
    chk("d1_Y", {Y1, Y2}, 32'h34);

    // Three-word instruction with constant.
    run_instr(32'h40, $urandom, 32'h8000_0000, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("d2_const", constant, 32'hDEAD_BEEF);
    chk("d2_cc", 32'(const_c), 1);

    // Delayed ack on word0, then halt held for 5 cycles.
    run_instr(32'h80, $urandom, 32'h0, 32'h0, 3, 0, 0, 0);
    run_instr(32'h100, 32'h0300_0000, 32'h0, 32'h0, 0, 1, 0, 5);

    // Reserved bits set: decoded but no write, illegal sticks.
    run_instr(32'h120, 32'h0300_0000, 32'h0000_0001, 32'h0, 0, 0, 0, 0);
    chk("d5_ill", 32'(illegal), 1);
    run_instr(32'h130, $urandom, 32'h0, 32'h0, 0, 0, 0, 1);

    // Address wrap at the top of the address space.
    run_instr(32'hFFFF_FFFF, $urandom, 32'hC000_0000, $urandom, 1, 0, 1, 0);

    // Asynchronous reset in FETCH2 with an ack in flight.
    program_counter = 32'h200;
    tick();
    fetch_word(32'h200, $urandom, 0);
    fetch_word(32'h201, 32'h8000_0000, 0);
    chk("f2_addr", imem_addr, 32'h202);
    imem_ack = 1'b1;
    imem_data = 32'h1234_5678;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    tick();
    chk("rst_issue", 32'(issue), 0);
    chk("rst_req", 32'(imem_req), 0);
    rst_n = 1'b1;
    imem_ack = 1'b0;
    ill_model = 1'b0;
    const_model = '0;
    run_instr(32'h300, $urandom, 32'h0, 32'h0, 0, 0, 0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      pc = ($urandom % 4 == 0) ? (32'hFFFF_FFFF - ($urandom % 3)) : $urandom;
      w0 = $urandom;
      w1 = $urandom;
      if ($urandom % 4 != 0) w1 = w1 & 32'hFFC0_0000;
      run_instr(pc, w0, w1, $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
